// File: rtl/icache_nway_pkg.sv
// rtl/icache_nway_pkg.sv - shared defaults, miss FSM encoding and derived widths for icache_nway
package icache_nway_pkg;

    localparam int ICACHE_WAYS     = 2;
    localparam int ICACHE_SET_LOG2 = 6;
    localparam int ICACHE_OFF_LOG2 = 6;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MISS_REQ  = 2'd1,
        ST_MISS_WAIT = 2'd2,
        ST_REFILL    = 2'd3
    } state_t;

    function automatic int tag_wd(input int set_log2, input int off_log2);
        return 32 - set_log2 - off_log2;
    endfunction

    function automatic int line_wd(input int off_log2);
        return 8 << off_log2;
    endfunction

endpackage

// File: rtl/icache_way_data.sv
// rtl/icache_way_data.sv - one way of line storage, synchronous read of the selected 64-bit word
module icache_way_data
    import icache_nway_pkg::*;
#(
    parameter int SET_LOG2 = ICACHE_SET_LOG2,
    parameter int OFF_LOG2 = ICACHE_OFF_LOG2,
    parameter int WORD_W   = (OFF_LOG2 > 3) ? OFF_LOG2 - 3 : 1
) (
    input  logic                           clk,
    input  logic                           i_we,
    input  logic [SET_LOG2-1:0]            i_waddr,
    input  logic [line_wd(OFF_LOG2)-1:0]   i_wdata,
    input  logic [SET_LOG2-1:0]            i_raddr,
    input  logic [WORD_W-1:0]              i_rword,
    output logic [63:0]                    o_rdata
);

    logic [line_wd(OFF_LOG2)-1:0] r_mem [1<<SET_LOG2];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr][{i_rword, 6'd0} +: 64];
    end

endmodule

// File: rtl/icache_nway.sv
// rtl/icache_nway.sv - N-way set-associative icache with miss FSM, refill handshake and perf counters
module icache_nway
    import icache_nway_pkg::*;
#(
    parameter int WAYS     = ICACHE_WAYS,
    parameter int SET_LOG2 = ICACHE_SET_LOG2,
    parameter int OFF_LOG2 = ICACHE_OFF_LOG2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inst_sram_en,
    input  logic [31:0]                  inst_sram_addr,
    output logic [63:0]                  inst_sram_rdata,
    output logic                         stallreq,
    output logic                         rd_req,
    output logic [31:0]                  rd_addr,
    input  logic                         rd_ready,
    input  logic                         reload,
    input  logic [(8<<OFF_LOG2)-1:0]     cacheline_new,
    input  logic                         inval,
    output logic [31:0]                  hit_cnt,
    output logic [31:0]                  miss_cnt
);

    localparam int TAG_WD = tag_wd(SET_LOG2, OFF_LOG2);
    localparam int SETS   = 1 << SET_LOG2;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WORD_W = (OFF_LOG2 > 3) ? OFF_LOG2 - 3 : 1;

    state_t              r_state, w_next_state;
    logic [TAG_WD-1:0]   r_tag [WAYS][SETS];
    logic [SETS-1:0]     r_valid [WAYS];
    logic [WAY_W-1:0]    r_rr [SETS];
    logic [WAY_W-1:0]    r_vict_way;
    logic                r_vict_rr;
    logic [TAG_WD-1:0]   r_miss_tag;
    logic [SET_LOG2-1:0] r_miss_idx;
    logic                r_inval_pend;
    logic                r_hit_q;
    logic [WAY_W-1:0]    r_hit_way;
    logic [31:0]         r_hit_cnt, r_miss_cnt;

    logic [TAG_WD-1:0]   w_tag;
    logic [SET_LOG2-1:0] w_idx;
    logic [WORD_W-1:0]   w_word;
    logic [WAYS-1:0]     w_match;
    logic [WAY_W-1:0]    w_hit_way, w_vict;
    logic                w_vict_rr, w_idle, w_inval_now, w_lookup, w_hit, w_miss, w_fill;
    logic [63:0]         w_way_rdata [WAYS];
    logic                w_unused;

    assign w_tag    = inst_sram_addr[31 -: TAG_WD];
    assign w_idx    = inst_sram_addr[OFF_LOG2 +: SET_LOG2];
    assign w_unused = ^inst_sram_addr[2:0];

    generate
        if (OFF_LOG2 > 3) begin : g_word
            assign w_word = inst_sram_addr[OFF_LOG2-1:3];
        end else begin : g_one_word
            assign w_word = '0;
        end
    endgenerate

    // A pending or fresh invalidate owns the first IDLE cycle; no lookup happens then.
    assign w_idle      = (r_state == ST_IDLE);
    assign w_inval_now = w_idle & (inval | r_inval_pend);
    assign w_lookup    = w_idle & inst_sram_en & ~w_inval_now;
    assign w_hit       = w_lookup & (|w_match);
    assign w_miss      = w_lookup & ~(|w_match);
    assign w_fill      = (r_state == ST_MISS_WAIT) & reload;
    assign stallreq    = ~w_idle | w_inval_now | (inst_sram_en & ~w_hit);

    always_comb begin
        w_hit_way = '0;
        w_vict    = r_rr[w_idx];
        w_vict_rr = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
            w_match[w] = r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag);
            if (w_match[w]) begin
                w_hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w][w_idx]) begin
                w_vict    = WAY_W'(w);
                w_vict_rr = 1'b0;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        rd_req       = 1'b0;
        case (r_state)
            ST_IDLE:      if (w_miss) w_next_state = ST_MISS_REQ;
            ST_MISS_REQ: begin
                rd_req = 1'b1;
                if (rd_ready) w_next_state = ST_MISS_WAIT;
            end
            ST_MISS_WAIT: if (reload) w_next_state = ST_REFILL;
            ST_REFILL:    w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    assign rd_addr = {r_miss_tag, r_miss_idx, {OFF_LOG2{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_inval_pend <= 1'b0;
            r_hit_q      <= 1'b0;
            r_hit_way    <= '0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
            r_vict_way   <= '0;
            r_vict_rr    <= 1'b0;
            r_miss_tag   <= '0;
            r_miss_idx   <= '0;
            for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
            for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
        end else begin
            r_state   <= w_next_state;
            r_hit_q   <= w_hit;
            r_hit_way <= w_hit_way;
            if (w_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
            if (w_miss) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
                r_vict_way <= w_vict;
                r_vict_rr  <= w_vict_rr;
                r_miss_tag <= w_tag;
                r_miss_idx <= w_idx;
            end
            if (w_inval_now) begin
                for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
                r_inval_pend <= 1'b0;
            end else if (!w_idle && inval) begin
                r_inval_pend <= 1'b1;
            end
            if (w_fill) begin
                r_valid[r_vict_way][r_miss_idx] <= 1'b1;
                if (r_vict_rr) begin
                    r_rr[r_miss_idx] <= (r_rr[r_miss_idx] == WAY_W'(WAYS - 1)) ? '0
                                        : r_rr[r_miss_idx] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[r_vict_way][r_miss_idx] <= r_miss_tag;
        end
    end

    genvar g;
    generate
        for (g = 0; g < WAYS; g++) begin : g_way
            icache_way_data #(.SET_LOG2(SET_LOG2), .OFF_LOG2(OFF_LOG2)) u_data (
                .clk     (clk),
                .i_we    (w_fill && (r_vict_way == WAY_W'(g))),
                .i_waddr (r_miss_idx),
                .i_wdata (cacheline_new),
                .i_raddr (w_idx),
                .i_rword (w_word),
                .o_rdata (w_way_rdata[g])
            );
        end
    endgenerate

    assign inst_sram_rdata = r_hit_q ? w_way_rdata[r_hit_way] : 64'd0;
    assign hit_cnt         = r_hit_cnt;
    assign miss_cnt        = r_miss_cnt;

endmodule

// File: tb/tb_icache_nway.sv
// tb/tb_icache_nway.sv - directed and randomized checks of icache_nway against a cache model
module tb_icache_nway;

    localparam int WAYS     = 2;
    localparam int SET_LOG2 = 6;
    localparam int OFF_LOG2 = 6;
    localparam int LINE_WD  = 8 << OFF_LOG2;
    localparam int SETS     = 1 << SET_LOG2;

    logic               clk = 1'b0;
    logic               rst, en, rd_ready, reload, inval;
    logic [31:0]        addr;
    logic [63:0]        rdata;
    logic               stall, rd_req;
    logic [31:0]        rd_addr, hit_cnt, miss_cnt;
    logic [LINE_WD-1:0] line;

    always #5 clk = ~clk;

    icache_nway #(.WAYS(WAYS), .SET_LOG2(SET_LOG2), .OFF_LOG2(OFF_LOG2)) dut (
        .clk(clk), .rst(rst), .inst_sram_en(en), .inst_sram_addr(addr),
        .inst_sram_rdata(rdata), .stallreq(stall), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ready(rd_ready), .reload(reload), .cacheline_new(line), .inval(inval),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Cache model: what each set holds, plus where the miss transaction stands.
    typedef enum {M_READY, M_REQUEST, M_AWAIT, M_BUBBLE} mphase_t;
    bit                 m_valid [WAYS][SETS];
    int unsigned        m_tag   [WAYS][SETS];
    logic [LINE_WD-1:0] m_line  [WAYS][SETS];
    int                 m_rr    [SETS];
    mphase_t            m_phase;
    bit                 m_pend, m_live, m_stall, m_vict_rr;
    int                 m_vict;
    int unsigned        m_laddr, m_hits, m_misses;
    logic [63:0]        m_rdata;

    int unsigned c_tag, c_idx, c_word;
    int          c_hw;
    bit          c_hit, c_stall;

    always @(negedge clk) begin
        if (rst) begin
            foreach (m_valid[w, s]) m_valid[w][s] = 1'b0;
            foreach (m_rr[s]) m_rr[s] = 0;
            m_phase = M_READY; m_pend = 0; m_rdata = 0; m_hits = 0; m_misses = 0;
            m_live = 1; m_stall = 0;
        end else if (m_live) begin
            c_tag  = addr >> (SET_LOG2 + OFF_LOG2);
            c_idx  = (addr >> OFF_LOG2) % SETS;
            c_word = (addr % (1 << OFF_LOG2)) / 8;
            c_hw   = -1;
            for (int w = 0; w < WAYS; w++)
                if (m_valid[w][c_idx] && m_tag[w][c_idx] == c_tag) c_hw = w;
            c_hit   = en && m_phase == M_READY && !m_pend && !inval && c_hw >= 0;
            c_stall = m_phase != M_READY || m_pend || inval || (en && !c_hit);
            m_stall = c_stall;

            chk("stallreq", stall, c_stall);
            chk("rd_req", rd_req, m_phase == M_REQUEST);
            if (m_phase == M_REQUEST) chk("rd_addr", rd_addr, m_laddr);
            chk("rdata", rdata, m_rdata);
            chk("hit_cnt", hit_cnt, m_hits);
            chk("miss_cnt", miss_cnt, m_misses);
            chk("single_way_match", $countones(dut.w_match) <= 1, 1);

            m_rdata = c_hit ? m_line[c_hw][c_idx][c_word*64 +: 64] : 64'd0;
            if (m_phase != M_READY && inval) m_pend = 1;
            case (m_phase)
                M_READY: begin
                    if (inval || m_pend) begin
                        foreach (m_valid[w, s]) m_valid[w][s] = 1'b0;
                        m_pend = 0;
                    end else if (c_hit) begin
                        m_hits++;
                    end else if (en) begin
                        m_misses++;
                        m_vict = -1;
                        for (int w = 0; w < WAYS; w++)
                            if (m_vict < 0 && !m_valid[w][c_idx]) m_vict = w;
                        m_vict_rr = (m_vict < 0);
                        if (m_vict_rr) m_vict = m_rr[c_idx];
                        m_laddr = addr & ~((32'd1 << OFF_LOG2) - 1);
                        m_phase = M_REQUEST;
                    end
                end
                M_REQUEST: if (rd_ready) m_phase = M_AWAIT;
                M_AWAIT: if (reload) begin
                    c_idx = (m_laddr >> OFF_LOG2) % SETS;
                    m_valid[m_vict][c_idx] = 1'b1;
                    m_tag[m_vict][c_idx]   = m_laddr >> (SET_LOG2 + OFF_LOG2);
                    m_line[m_vict][c_idx]  = line;
                    if (m_vict_rr) m_rr[c_idx] = (m_rr[c_idx] + 1) % WAYS;
                    m_phase = M_BUBBLE;
                end
                M_BUBBLE: m_phase = M_READY;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned t, i;
        t = $urandom_range(0, 4) * 13;
        case ($urandom_range(0, 2))
            0: i = 5;
            1: i = 0;
            default: i = SETS - 1;
        endcase
        return (t << (SET_LOG2 + OFF_LOG2)) | (i << OFF_LOG2) | ($urandom % (1 << OFF_LOG2));
    endfunction

    logic [LINE_WD-1:0] golden;
    bit                 seen;

    initial begin
        rst = 1; en = 0; addr = 0; rd_ready = 0; reload = 0; inval = 0; line = '0;
        for (int k = 0; k < LINE_WD / 64; k++) golden[k*64 +: 64] = {32'hDEADBEEF, 32'hCAFEF00D + k};
        tick(); tick();
        rst = 0;
        sample();
        chk("reset_hit_cnt", hit_cnt, 0);
        chk("reset_miss_cnt", miss_cnt, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_rd_req", rd_req, 0);

        // Cold miss with a slow bridge and a stray reload while the request is outstanding
        tick(); en = 1; addr = 32'h1FC0_0044;
        sample(); chk("cold_stall", stall, 1);
        tick(); sample();
        chk("cold_rd_req", rd_req, 1);
        chk("cold_rd_addr", rd_addr, 32'h1FC0_0040);
        for (int i = 0; i < 20; i++) begin
            tick(); reload = (i == 5); line = '1;
            sample(); chk("held_rd_addr", rd_addr, 32'h1FC0_0040);
        end
        tick(); reload = 0; rd_ready = 1; sample();
        tick(); rd_ready = 0; sample();
        tick(); reload = 1; line = golden; sample();
        tick(); reload = 0; sample(); chk("refill_bubble", stall, 1);
        tick(); sample(); chk("relookup_stall", stall, 0);
        tick(); en = 0; sample();
        chk("cold_rdata", rdata, 64'hDEADBEEF_CAFEF00D);
        chk("cold_hit_cnt", hit_cnt, 1);
        chk("cold_miss_cnt", miss_cnt, 1);

        // Back-to-back hits through the whole line
        for (int i = 0; i < 8; i++) begin
            tick(); en = 1; addr = 32'h1FC0_0040 + 8 * i;
            sample(); chk("seq_stall", stall, 0);
            if (i > 0) chk("seq_rdata", rdata, {32'hDEADBEEF, 32'hCAFEF00D + i - 1});
        end
        tick(); en = 0; sample();
        chk("seq_last_rdata", rdata, {32'hDEADBEEF, 32'hCAFEF00D + 32'd7});
        chk("seq_hit_cnt", hit_cnt, 9);

        // Reset while waiting for the line; the late reload must not land
        tick(); en = 1; addr = 32'h0000_1000; sample();
        tick(); rd_ready = 1; sample();
        tick(); rd_ready = 0; sample();
        tick(); rst = 1; sample();
        tick(); rst = 0; en = 0; reload = 1; sample();
        chk("abort_rd_req", rd_req, 0);
        chk("abort_miss_cnt", miss_cnt, 0);
        chk("abort_hit_cnt", hit_cnt, 0);
        tick(); reload = 0; en = 1; addr = 32'h0000_1000; sample();
        chk("refetch_stall", stall, 1);
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            tick(); sample(); seen = rd_req;
        end
        chk("refetch_rd_req", seen, 1);

        for (int c = 0; c < 5000; c++) begin
            tick();
            if (!m_stall) begin
                en   = ($urandom % 4) != 0;
                addr = rand_addr();
            end
            rd_ready = ($urandom % 3) == 0;
            reload   = (m_phase == M_AWAIT) ? (($urandom % 3) == 0) : (($urandom % 60) == 0);
            if (reload)
                for (int k = 0; k < LINE_WD / 32; k++) line[k*32 +: 32] = $urandom;
            inval = ($urandom % 40) == 0;
            rst   = ($urandom % 700) == 0;
        end
        tick(); rst = 0; inval = 0; reload = 0; en = 0;
        sample();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
